// File: rtl/regfile_pkg.sv
// Shared types and constants for the YASAC register file: register/address
// types, SREG flag bit positions and the R7:R6 pointer register indices.
package regfile_pkg;

    localparam int NUM_REGS = 8;

    typedef logic [7:0]  data_t;
    typedef logic [2:0]  raddr_t;
    typedef logic [15:0] ptr_t;

    // SREG flag bit positions
    localparam int CF = 0;
    localparam int ZF = 1;
    localparam int NF = 2;
    localparam int VF = 3;
    localparam int SF = 4;

    // Indirect-addressing pointer pair {R7, R6}
    localparam raddr_t PTR_LO = 3'd6;
    localparam raddr_t PTR_HI = 3'd7;

    function automatic logic is_ptr_reg(input raddr_t addr);
        return (addr == PTR_LO) || (addr == PTR_HI);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register-file side bus: ALU operand reads, result/status writeback,
// single-flag set/clear and pointer post-increment.
// master = sequencer/ALU side, slave = register file.
interface regfile_if;
    import regfile_pkg::*;

    raddr_t ra_sel;
    raddr_t rb_sel;
    data_t  a;
    data_t  b;
    logic   we;
    raddr_t wd_sel;
    data_t  wd;
    logic   st_we;
    data_t  st_d;
    logic   fset;
    logic   fclr;
    raddr_t fbit;
    data_t  st;
    logic   ptr_inc;
    ptr_t   ptr;

    modport master (
        output ra_sel, rb_sel, we, wd_sel, wd, st_we, st_d,
               fset, fclr, fbit, ptr_inc,
        input  a, b, st, ptr
    );

    modport slave (
        input  ra_sel, rb_sel, we, wd_sel, wd, st_we, st_d,
               fset, fclr, fbit, ptr_inc,
        output a, b, st, ptr
    );

endinterface

// File: rtl/regfile_sreg.sv
// Status register: load from the ALU status, then a single-flag set/clear
// applied on top (set beats clear). Output is registered only, so there is
// no combinational path from st_d/fset/fclr to st.
module regfile_sreg
    import regfile_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   st_we_i,
    input  data_t  st_d_i,
    input  logic   fset_i,
    input  logic   fclr_i,
    input  raddr_t fbit_i,
    output data_t  st_o
);

    data_t sreg_q;
    data_t sreg_d;

    // Next SREG: hold, optional load, then a single-bit override
    always_comb begin
        sreg_d = sreg_q;
        if (st_we_i) begin
            sreg_d = st_d_i;
        end
        if (fset_i) begin
            sreg_d[fbit_i] = 1'b1;
        end else if (fclr_i) begin
            sreg_d[fbit_i] = 1'b0;
        end
    end

    // SREG state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign st_o = sreg_q;

endmodule

// File: rtl/regfile.sv
// YASAC general-purpose register file (8 x 8 bit) with SREG and R7:R6
// pointer post-increment.
// Build option: REGFILE_BYPASS_EN enables write-first forwarding of wd onto
// a/b and, per byte, onto ptr. SREG is never forwarded.
module regfile
    import regfile_pkg::*;
(
    input logic      clk,
    input logic      reset,
    regfile_if.slave bus
);

    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];
    ptr_t  ptr_cur;
    ptr_t  ptr_nxt;
    logic  ptr_wr_hit;
    data_t st_w;

    assign ptr_cur    = {regs_q[PTR_HI], regs_q[PTR_LO]};
    assign ptr_nxt    = ptr_cur + 16'd1;
    // A write to either pointer byte drops the whole increment
    assign ptr_wr_hit = bus.we && is_ptr_reg(bus.wd_sel);

    // Next array contents: pointer increment first, explicit write last
    always_comb begin
        regs_d = regs_q;
        if (bus.ptr_inc && !ptr_wr_hit) begin
            regs_d[PTR_LO] = ptr_nxt[7:0];
            regs_d[PTR_HI] = ptr_nxt[15:8];
        end
        if (bus.we) begin
            regs_d[bus.wd_sel] = bus.wd;
        end
    end

    // Register array with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Operand and pointer read ports
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        bus.a   = (bus.we && (bus.wd_sel == bus.ra_sel)) ? bus.wd : regs_q[bus.ra_sel];
        bus.b   = (bus.we && (bus.wd_sel == bus.rb_sel)) ? bus.wd : regs_q[bus.rb_sel];
        bus.ptr = {(bus.we && (bus.wd_sel == PTR_HI)) ? bus.wd : regs_q[PTR_HI],
                   (bus.we && (bus.wd_sel == PTR_LO)) ? bus.wd : regs_q[PTR_LO]};
`else
        bus.a   = regs_q[bus.ra_sel];
        bus.b   = regs_q[bus.rb_sel];
        bus.ptr = ptr_cur;
`endif
    end

    regfile_sreg u_sreg (
        .clk     (clk),
        .reset   (reset),
        .st_we_i (bus.st_we),
        .st_d_i  (bus.st_d),
        .fset_i  (bus.fset),
        .fclr_i  (bus.fclr),
        .fbit_i  (bus.fbit),
        .st_o    (st_w)
    );

    assign bus.st = st_w;

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: each driven cycle pushes the expected
// a/b/st/ptr into a queue; a negedge monitor pops and compares.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_if bus ();

    regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit       rst;
        bit [2:0] ra, rb;
        bit       we;
        bit [2:0] wsel;
        bit [7:0] wd;
        bit       stwe;
        bit [7:0] std;
        bit       fs, fc;
        bit [2:0] fb;
        bit       pinc;
    } stim_t;

    typedef struct {
        int    a, b, st, ptr;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: plain integers
    int m_r[8];
    int m_st;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic cmp(input string nm, input string fld, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.nm, "a",   int'(bus.a),   e.a);
            cmp(e.nm, "b",   int'(bus.b),   e.b);
            cmp(e.nm, "st",  int'(bus.st),  e.st);
            cmp(e.nm, "ptr", int'(bus.ptr), e.ptr);
        end
    end

    task automatic step(input stim_t s, input string nm, input bit chk);
        exp_t e;
        int   p;
        int   nr[8];
        @(posedge clk);
        #1;
        reset       = s.rst;
        bus.ra_sel  = s.ra;
        bus.rb_sel  = s.rb;
        bus.we      = s.we;
        bus.wd_sel  = s.wsel;
        bus.wd      = s.wd;
        bus.st_we   = s.stwe;
        bus.st_d    = s.std;
        bus.fset    = s.fs;
        bus.fclr    = s.fc;
        bus.fbit    = s.fb;
        bus.ptr_inc = s.pinc;
        if (chk) begin
            e.nm  = nm;
            e.a   = (BYP && s.we && s.wsel == s.ra) ? int'(s.wd) : m_r[s.ra];
            e.b   = (BYP && s.we && s.wsel == s.rb) ? int'(s.wd) : m_r[s.rb];
            e.st  = m_st;
            e.ptr = ((BYP && s.we && s.wsel == 3'd7) ? int'(s.wd) : m_r[7]) * 256
                  + ((BYP && s.we && s.wsel == 3'd6) ? int'(s.wd) : m_r[6]);
            sb.push_back(e);
        end
        if (s.rst) begin
            foreach (m_r[i]) m_r[i] = 0;
            m_st = 0;
        end else begin
            nr = m_r;
            if (s.pinc && !(s.we && (s.wsel == 3'd6 || s.wsel == 3'd7))) begin
                p = (m_r[7] * 256 + m_r[6] + 1) % 65536;
                nr[6] = p % 256;
                nr[7] = p / 256;
            end
            if (s.we) nr[s.wsel] = int'(s.wd);
            m_r = nr;
            if (s.stwe) m_st = int'(s.std);
            if (s.fs)      m_st = m_st | (1 << s.fb);
            else if (s.fc) m_st = m_st & ~(1 << s.fb) & 8'hFF;
        end
    endtask

    task automatic wr(input bit [2:0] sel, input bit [7:0] d, input string nm);
        stim_t s;
        s = idle();
        s.we = 1'b1; s.wsel = sel; s.wd = d;
        step(s, nm, 1'b1);
    endtask

    initial begin
        stim_t s;
        int    sum;
        bit [7:0] r8;
        bit [7:0] fl;

        foreach (m_r[i]) m_r[i] = 0;
        m_st = 0;
        s = idle(); s.rst = 1'b1;
        step(s, "rst0", 1'b0);

        // reset state, write/read R3, re-reset
        s = idle(); s.ra = 3; s.rb = 6;
        step(s, "rst_state", 1'b1);
        wr(3, 8'hA5, "wr_r3");
        s = idle(); s.ra = 3; s.rb = 3;
        step(s, "rd_r3", 1'b1);
        s = idle(); s.rst = 1'b1; s.ra = 3; s.stwe = 1; s.std = 8'hFF; s.pinc = 1;
        step(s, "rst_mid", 1'b1);
        s = idle(); s.ra = 3;
        step(s, "after_rst", 1'b1);

        // pointer carry and wrap
        wr(6, 8'hFF, "p_lo");
        wr(7, 8'h00, "p_hi");
        s = idle(); s.pinc = 1;
        step(s, "pinc_carry", 1'b1);
        wr(6, 8'hFF, "p_lo2");
        wr(7, 8'hFF, "p_hi2");
        s = idle(); s.pinc = 1;
        step(s, "pinc_wrap", 1'b1);
        s = idle();
        step(s, "wrapped", 1'b1);

        // SREG load with flag ops, including upper bit and set-over-clear
        s = idle(); s.stwe = 1; s.std = 8'h1F; s.fc = 1; s.fb = 1;
        step(s, "st_ld_clr", 1'b1);
        s = idle(); s.fs = 1; s.fc = 1; s.fb = 7;
        step(s, "st_set7", 1'b1);
        s = idle();
        step(s, "st_hold", 1'b1);

        // pointer collision and non-colliding write
        wr(7, 8'h00, "c_hi");
        wr(6, 8'h10, "c_lo");
        s = idle(); s.pinc = 1; s.we = 1; s.wsel = 6; s.wd = 8'h40; s.ra = 6;
        step(s, "coll_r6", 1'b1);
        s = idle(); s.pinc = 1; s.we = 1; s.wsel = 2; s.wd = 8'h5A; s.ra = 2;
        step(s, "coll_r2", 1'b1);
        s = idle(); s.ra = 2; s.rb = 6;
        step(s, "post_r2", 1'b1);

        // read during write to the same address
        wr(5, 8'h11, "r5_old");
        s = idle(); s.we = 1; s.wsel = 5; s.wd = 8'h77; s.ra = 5; s.rb = 5;
        step(s, "rdw_r5", 1'b1);
        s = idle(); s.ra = 5;
        step(s, "r5_new", 1'b1);

        // ALU loop-back: R0 = R0 + R1 with status writeback
        wr(0, 8'h7F, "alu_r0");
        wr(1, 8'h01, "alu_r1");
        sum = 8'h7F + 8'h01;
        r8  = sum[7:0];
        fl  = '0;
        fl[0] = sum > 255;
        fl[1] = (r8 == 0);
        fl[2] = r8[7];
        fl[3] = (r8[7] != 1'b0);
        fl[4] = fl[2] ^ fl[3];
        s = idle(); s.ra = 0; s.rb = 1; s.we = 1; s.wsel = 0; s.wd = r8;
        s.stwe = 1; s.std = fl;
        step(s, "alu_add", 1'b1);
        s = idle(); s.ra = 0;
        step(s, "alu_res", 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 39) == 0);
            s.ra   = 3'($urandom_range(0, 7));
            s.rb   = 3'($urandom_range(0, 7));
            s.we   = s.rst ? 1'b0 : 1'($urandom_range(0, 1));
            s.wsel = 3'($urandom_range(0, 7));
            s.wd   = 8'($urandom);
            s.stwe = 1'($urandom_range(0, 1));
            s.std  = 8'($urandom);
            s.fs   = ($urandom_range(0, 3) == 0);
            s.fc   = ($urandom_range(0, 3) == 0);
            s.fb   = 3'($urandom_range(0, 7));
            s.pinc = 1'($urandom_range(0, 1));
            step(s, "rand", 1'b1);
        end

        s = idle();
        step(s, "final", 1'b1);
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
